// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_pkg
//  Purpose  : Shared parameters and types for the writeback arbiter.
//             - Default register-index / operand widths and queue depth.
//             - Queue entry layout: {rd, data}, with rd in the upper bits.
//             - Source identifier enum, used as the round-robin state.
//  Macros   : none
//  Revision : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

  localparam int unsigned W_RD_DEFAULT       = 4;
  localparam int unsigned W_OPR_DEFAULT      = 32;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

  // Reference layout of one queue entry at default widths. The arbiter packs
  // entries as {rd, data} for any width, in this same field order.
  typedef struct packed {
    logic [W_RD_DEFAULT-1:0]  rd;
    logic [W_OPR_DEFAULT-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

  // Round-robin successor of a granted source.
  function automatic src_e other_src(input src_e s);
    return (s == SRC0) ? SRC1 : SRC0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_if
//  Purpose  : Bundles the two source handshakes and the register-file write
//             port of the writeback arbiter.
//  Ports    : clk - clock seen by both sides
//  Modports : master - result producers and register-file observer
//             slave  - the arbiter
//  Macros   : none
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned W_RD  = W_RD_DEFAULT,
  parameter int unsigned W_OPR = W_OPR_DEFAULT
) (
  input logic clk
);
  logic             src0_valid;
  logic [W_RD-1:0]  src0_rd;
  logic [W_OPR-1:0] src0_data;
  logic             src0_ready;
  logic             src1_valid;
  logic [W_RD-1:0]  src1_rd;
  logic [W_OPR-1:0] src1_data;
  logic             src1_ready;
  logic             wb;
  logic [W_RD-1:0]  wb_r;
  logic [W_OPR-1:0] result;

  modport master (
    input  clk,
    output src0_valid, src0_rd, src0_data,
    input  src0_ready,
    output src1_valid, src1_rd, src1_data,
    input  src1_ready,
    input  wb, wb_r, result
  );

  modport slave (
    input  clk,
    input  src0_valid, src0_rd, src0_data,
    output src0_ready,
    input  src1_valid, src1_rd, src1_data,
    output src1_ready,
    output wb, wb_r, result
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : Small per-source queue. DEPTH must be a power of two >= 2 so
//             the read/write pointers wrap naturally.
//  Ports    : clk, reset - clock, synchronous active-high reset
//             push_i     - write din_i (caller guarantees not full)
//             pop_i      - drop head (caller guarantees not empty)
//             din_i      - entry to enqueue
//             head_o     - oldest entry (undefined while empty)
//             count_o    - registered occupancy, 0..DEPTH
//  Macros   : none
//  Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Simultaneous push and pop leaves the occupancy unchanged.
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read before the pointers move.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Merges results from two execution sources into the single
//             register-file write port. Each source has its own queue; a
//             round-robin arbiter picks one head per cycle into a registered
//             write strobe / index / value.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             srcN_valid_i/rd_i/data_i, srcN_ready_o - source N handshake
//             wb_o, wb_r_o, result_o               - register-file write
//  Macros   : WB_BYPASS_EN - a beat arriving at an empty queue competes in
//             arbitration the same cycle (writeback one cycle earlier).
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned W_RD       = W_RD_DEFAULT,
  parameter int unsigned W_OPR      = W_OPR_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src0_valid_i,
  input  logic [W_RD-1:0]  src0_rd_i,
  input  logic [W_OPR-1:0] src0_data_i,
  output logic             src0_ready_o,
  input  logic             src1_valid_i,
  input  logic [W_RD-1:0]  src1_rd_i,
  input  logic [W_OPR-1:0] src1_data_i,
  output logic             src1_ready_o,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic [W_OPR-1:0] result_o
);
  localparam int unsigned W_ENT = W_RD + W_OPR;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]             valid, ready, accept, nonempty, cand, grant, push, pop;
  logic [1:0][W_ENT-1:0]  in_ent, fifo_head, cand_ent;
  logic [1:0][CW-1:0]     count;
  logic [W_ENT-1:0]       win_ent;

  src_e                   rr_q, rr_d;
  logic                   wb_q, wb_d;
  logic [W_RD-1:0]        wb_r_q, wb_r_d;
  logic [W_OPR-1:0]       result_q, result_d;

  assign valid[0]     = src0_valid_i;
  assign valid[1]     = src1_valid_i;
  assign in_ent[0]    = {src0_rd_i, src0_data_i};
  assign in_ent[1]    = {src1_rd_i, src1_data_i};
  assign src0_ready_o = ready[0];
  assign src1_ready_o = ready[1];

  for (genvar s = 0; s < 2; s++) begin : g_src
    wb_fifo #(
      .WIDTH (W_ENT),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[s]),
      .pop_i   (pop[s]),
      .din_i   (in_ent[s]),
      .head_o  (fifo_head[s]),
      .count_o (count[s])
    );

    // Ready depends only on the registered count, never on valid.
    assign ready[s]    = (count[s] < CW'(FIFO_DEPTH));
    assign nonempty[s] = (count[s] != '0);
    assign accept[s]   = valid[s] & ready[s];
    assign pop[s]      = grant[s] & nonempty[s];
`ifdef WB_BYPASS_EN
    // A beat arriving at an empty queue may win immediately; it is only
    // enqueued when it loses.
    assign cand[s]     = nonempty[s] | accept[s];
    assign cand_ent[s] = nonempty[s] ? fifo_head[s] : in_ent[s];
    assign push[s]     = accept[s] & ~(grant[s] & ~nonempty[s]);
`else
    assign cand[s]     = nonempty[s];
    assign cand_ent[s] = fifo_head[s];
    assign push[s]     = accept[s];
`endif
  end

  assign win_ent = grant[1] ? cand_ent[1] : cand_ent[0];

  // rr_q names the source that wins when both compete.
  always_comb begin
    grant    = '0;
    rr_d     = rr_q;
    wb_d     = 1'b0;
    wb_r_d   = wb_r_q;
    result_d = result_q;
    if (cand[0] && (!cand[1] || rr_q == SRC0)) begin
      grant[0] = 1'b1;
      rr_d     = other_src(SRC0);
    end else if (cand[1]) begin
      grant[1] = 1'b1;
      rr_d     = other_src(SRC1);
    end
    if (|grant) begin
      wb_d               = 1'b1;
      {wb_r_d, result_d} = win_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q     <= SRC0;
      wb_q     <= 1'b0;
      wb_r_q   <= '0;
      result_q <= '0;
    end else begin
      rr_q     <= rr_d;
      wb_q     <= wb_d;
      wb_r_q   <= wb_r_d;
      result_q <= result_d;
    end
  end

  assign wb_o     = wb_q;
  assign wb_r_o   = wb_r_q;
  assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Self-checking bench for wb_arbiter. A queue-level reference
//             model predicts, for every clock edge, the write port and both
//             ready outputs; a monitor pops those predictions on the falling
//             edge and compares them with the design.
//  Macros   : WB_BYPASS_EN - selects the same-cycle bypass behaviour in the
//             reference model, matching the design build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int W_RD  = 4;
  localparam int W_OPR = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [W_RD-1:0]  rd;
    logic [W_OPR-1:0] data;
  } beat_t;

  typedef struct {
    logic             wb;
    logic [W_RD-1:0]  rd;
    logic [W_OPR-1:0] data;
    logic             rdy0;
    logic             rdy1;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_arbiter_if #(.W_RD(W_RD), .W_OPR(W_OPR)) bus (.clk(clk));

  wb_arbiter #(
    .W_RD       (W_RD),
    .W_OPR      (W_OPR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src0_valid_i (bus.src0_valid),
    .src0_rd_i    (bus.src0_rd),
    .src0_data_i  (bus.src0_data),
    .src0_ready_o (bus.src0_ready),
    .src1_valid_i (bus.src1_valid),
    .src1_rd_i    (bus.src1_rd),
    .src1_data_i  (bus.src1_data),
    .src1_ready_o (bus.src1_ready),
    .wb_o         (bus.wb),
    .wb_r_o       (bus.wb_r),
    .result_o     (bus.result)
  );

  // Beats waiting to be offered, beats held in the model queues, predictions.
  beat_t pend0[$], pend1[$], mq0[$], mq1[$];
  exp_t  sb[$];

  int               n_checks = 0;
  int               n_fails  = 0;
  int               rr_m     = 0;
  logic             wb_m     = 1'b0;
  logic [W_RD-1:0]  hold_rd  = '0;
  logic [W_OPR-1:0] hold_data = '0;
  logic             drv_v0, drv_v1;
  beat_t            drv_b0, drv_b1;

  function automatic beat_t mk(input int rd, input logic [W_OPR-1:0] d);
    beat_t b;
    b.rd   = W_RD'(rd);
    b.data = d;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model for one clock edge, using the inputs presented to it.
  task automatic model_edge();
    bit    acc0, acc1, c0, c1, g0, g1, byp0, byp1;
    beat_t b;
    byp0 = 0;
    byp1 = 0;
    if (reset) begin
      mq0.delete();
      mq1.delete();
      rr_m      = 0;
      wb_m      = 1'b0;
      hold_rd   = '0;
      hold_data = '0;
    end else begin
      acc0 = drv_v0 && (mq0.size() < DEPTH);
      acc1 = drv_v1 && (mq1.size() < DEPTH);
      c0   = mq0.size() > 0;
      c1   = mq1.size() > 0;
`ifdef WB_BYPASS_EN
      c0 = c0 || acc0;
      c1 = c1 || acc1;
`endif
      g0 = c0 && (!c1 || rr_m == 0);
      g1 = c1 && (!c0 || rr_m == 1);
      wb_m = g0 || g1;
      if (g0) begin
        if (mq0.size() > 0) b = mq0.pop_front();
        else begin b = drv_b0; byp0 = 1; end
        hold_rd = b.rd; hold_data = b.data; rr_m = 1;
      end else if (g1) begin
        if (mq1.size() > 0) b = mq1.pop_front();
        else begin b = drv_b1; byp1 = 1; end
        hold_rd = b.rd; hold_data = b.data; rr_m = 0;
      end
      if (acc0) begin
        void'(pend0.pop_front());
        if (!byp0) mq0.push_back(drv_b0);
      end
      if (acc1) begin
        void'(pend1.pop_front());
        if (!byp1) mq1.push_back(drv_b1);
      end
    end
    sb.push_back('{wb_m, hold_rd, hold_data, mq0.size() < DEPTH, mq1.size() < DEPTH});
  endtask

  // Offer pending beats (each source gated by a percentage), then clock once.
  task automatic cycle(input int gate0, input int gate1);
    drv_v0 = (pend0.size() > 0) && (int'($urandom_range(99)) < gate0);
    drv_v1 = (pend1.size() > 0) && (int'($urandom_range(99)) < gate1);
    drv_b0 = (pend0.size() > 0) ? pend0[0] : mk(int'($urandom), $urandom);
    drv_b1 = (pend1.size() > 0) ? pend1[0] : mk(int'($urandom), $urandom);
    bus.src0_valid = drv_v0;
    bus.src0_rd    = drv_b0.rd;
    bus.src0_data  = drv_b0.data;
    bus.src1_valid = drv_v1;
    bus.src1_rd    = drv_b1.rd;
    bus.src1_data  = drv_b1.data;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int cycles);
    pend0.delete();
    pend1.delete();
    reset = 1'b1;
    repeat (cycles) cycle(0, 0);
    reset = 1'b0;
  endtask

  // Monitor: one prediction per clock edge, compared at the falling edge.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL scoreboard_empty @%0t: got no prediction, required one", $time);
      end else begin
        e = sb.pop_front();
        check("wb_o",         64'(bus.wb),         64'(e.wb));
        check("wb_r_o",       64'(bus.wb_r),       64'(e.rd));
        check("result_o",     64'(bus.result),     64'(e.data));
        check("src0_ready_o", 64'(bus.src0_ready), 64'(e.rdy0));
        check("src1_ready_o", 64'(bus.src1_ready), 64'(e.rdy1));
      end
    end
  end

  initial begin
    reset = 1'b1;
    do_reset(3);

    // Single beat from source 0.
    pend0.push_back(mk(3, 32'h0000_1234));
    repeat (5) cycle(100, 100);

    // Both sources streaming: alternating writebacks starting with source 0.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      pend0.push_back(mk(1 + i, 32'h100 + 32'(i)));
      pend1.push_back(mk(8 + i, 32'h800 + 32'(i)));
    end
    repeat (14) cycle(100, 100);

    // Same destination register from both sources in the same cycle.
    do_reset(1);
    pend0.push_back(mk(5, 32'h0000_AAAA));
    pend1.push_back(mk(5, 32'h0000_5555));
    repeat (5) cycle(100, 100);

    // Source 0 streams; source 1 sends three back-to-back beats.
    do_reset(1);
    for (int i = 0; i < 12; i++) pend0.push_back(mk(i, $urandom));
    for (int i = 0; i < 3; i++)  pend1.push_back(mk(12 + i, $urandom));
    repeat (30) cycle(100, 100);

    // Reset with beats still queued: nothing queued may be written later.
    for (int i = 0; i < 4; i++) begin
      pend0.push_back(mk(i, $urandom));
      pend1.push_back(mk(8 + i, $urandom));
    end
    repeat (3) cycle(100, 100);
    do_reset(1);
    repeat (6) cycle(100, 100);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if (pend0.size() < 3) pend0.push_back(mk(int'($urandom), $urandom));
      if (pend1.size() < 3) pend1.push_back(mk(int'($urandom), $urandom));
      if ($urandom_range(99) == 0) do_reset(1 + int'($urandom_range(1)));
      else cycle(60, 60);
    end

    // Drain.
    pend0.delete();
    pend1.delete();
    repeat (8) cycle(0, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
